vga_scan_driver: RTL and testbench

- Display-side timing engine and reader for the pixel frame buffer.
- Generates 800x600@72Hz raster timing from a 50 MHz pixel clock.
- Drives the frame buffer's read coordinates (x, y) and takes the returned 12-bit colour.
- Outputs 4:4:4 RGB plus hsync/vsync aligned to the buffer's registered read latency, and pulses frame_trig once per frame at the start of vertical blanking.

---
 rtl/vga_scan_if.sv | 28 ++
 rtl/vga_scan_driver.sv | 130 +++++++++++++
 tb/tb_vga_scan_driver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// Frame-buffer read port and VGA output bundle of the scan driver.
interface vga_scan_if;
  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned COL_W = 12;
  localparam int unsigned CH_W  = 4;

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour_in;
  logic             frame_trig;
  logic [CH_W-1:0]  vga_r;
  logic [CH_W-1:0]  vga_g;
  logic [CH_W-1:0]  vga_b;
  logic             hsync;
  logic             vsync;
  logic             active;

  modport master (
    output x, y, frame_trig, vga_r, vga_g, vga_b, hsync, vsync, active,
    input  colour_in
  );

  modport slave (
    input  x, y, frame_trig, vga_r, vga_g, vga_b, hsync, vsync, active,
    output colour_in
  );
endinterface

// File: rtl/vga_scan_driver.sv
// Raster timing engine for a pixel frame buffer: generates read coordinates,
// realigns sync/enable with the buffer read latency and drives 4:4:4 RGB.
module vga_scan_driver #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FRONT    = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BACK     = 64,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FRONT    = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BACK     = 23,
  parameter int unsigned SYNC_POL   = 1,
  parameter int unsigned PIX_DIV    = 1,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  vga_scan_if.master    bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_W     = 11;
  localparam int unsigned V_W     = 10;
  localparam int unsigned DIV_W   = 3;
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  typedef enum logic [1:0] {REG_ACTIVE, REG_FRONT, REG_SYNC, REG_BACK} region_t;

  function automatic region_t h_decode(input logic [H_W-1:0] c);
    if (c < H_W'(H_ACTIVE))                          return REG_ACTIVE;
    else if (c < H_W'(H_ACTIVE + H_FRONT))           return REG_FRONT;
    else if (c < H_W'(H_ACTIVE + H_FRONT + H_SYNC))  return REG_SYNC;
    else                                             return REG_BACK;
  endfunction

  function automatic region_t v_decode(input logic [V_W-1:0] c);
    if (c < V_W'(V_ACTIVE))                          return REG_ACTIVE;
    else if (c < V_W'(V_ACTIVE + V_FRONT))           return REG_FRONT;
    else if (c < V_W'(V_ACTIVE + V_FRONT + V_SYNC))  return REG_SYNC;
    else                                             return REG_BACK;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_q, h_d, x_d;
  logic [V_W-1:0]   v_q, v_d, y_d;
  region_t          h_reg_q, h_reg_d, v_reg_q, v_reg_d;
  logic             trig_d;
  logic             tick_c, h_wrap_c;

  // Counter and region state register; x/y/frame_trig move with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q          <= '0;
      h_q            <= '0;
      v_q            <= '0;
      h_reg_q        <= REG_ACTIVE;
      v_reg_q        <= REG_ACTIVE;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.frame_trig <= 1'b0;
    end else begin
      div_q          <= div_d;
      h_q            <= h_d;
      v_q            <= v_d;
      h_reg_q        <= h_reg_d;
      v_reg_q        <= v_reg_d;
      bus.x          <= x_d;
      bus.y          <= y_d;
      bus.frame_trig <= trig_d;
    end
  end

  // Next-state: divider, counters, region decode of the next count.
  always_comb begin
    tick_c   = (div_q == DIV_W'(PIX_DIV - 1));
    h_wrap_c = (h_q == H_W'(H_TOTAL - 1));
    div_d    = tick_c ? '0 : div_q + DIV_W'(1);
    h_d      = h_q;
    v_d      = v_q;
    trig_d   = 1'b0;
    if (tick_c) begin
      h_d    = h_wrap_c ? '0 : h_q + H_W'(1);
      if (h_wrap_c) begin
        v_d  = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + V_W'(1);
      end
      trig_d = h_wrap_c && (v_q == V_W'(V_ACTIVE - 1));
    end
    h_reg_d  = h_decode(h_d);
    v_reg_d  = v_decode(v_d);
    x_d      = (h_reg_d == REG_ACTIVE) ? h_d : '0;
    y_d      = (v_reg_d == REG_ACTIVE) ? v_d : '0;
  end

  logic                  de_raw_c, hs_raw_c, vs_raw_c;
  logic [RD_LATENCY-1:0] de_pipe, hs_pipe, vs_pipe;

  assign de_raw_c = (h_reg_q == REG_ACTIVE) && (v_reg_q == REG_ACTIVE);
  assign hs_raw_c = (h_reg_q == REG_SYNC);
  assign vs_raw_c = (v_reg_q == REG_SYNC);

  // Delay enable/syncs by the buffer latency, then register with the colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_pipe    <= '0;
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      bus.vga_r  <= '0;
      bus.vga_g  <= '0;
      bus.vga_b  <= '0;
      bus.active <= 1'b0;
      bus.hsync  <= ~SYNC_ON;
      bus.vsync  <= ~SYNC_ON;
    end else begin
      de_pipe[0] <= de_raw_c;
      hs_pipe[0] <= hs_raw_c;
      vs_pipe[0] <= vs_raw_c;
      for (int i = 1; i < RD_LATENCY; i++) begin
        de_pipe[i] <= de_pipe[i-1];
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
      bus.vga_r  <= de_pipe[RD_LATENCY-1] ? bus.colour_in[11:8] : '0;
      bus.vga_g  <= de_pipe[RD_LATENCY-1] ? bus.colour_in[7:4]  : '0;
      bus.vga_b  <= de_pipe[RD_LATENCY-1] ? bus.colour_in[3:0]  : '0;
      bus.active <= de_pipe[RD_LATENCY-1];
      bus.hsync  <= hs_pipe[RD_LATENCY-1] ~^ SYNC_ON;
      bus.vsync  <= vs_pipe[RD_LATENCY-1] ~^ SYNC_ON;
    end
  end
endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver: two scaled-down raster instances
// (PIX_DIV=1/latency 1/active-high, PIX_DIV=2/latency 2/active-low).
module tb_vga_scan_driver;
  localparam int unsigned HA = 256, HF = 8, HS = 16, HB = 8;
  localparam int unsigned VA = 12,  VF = 2, VS = 3,  VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned PD0 = 1, LAT0 = 1, POL0 = 1;
  localparam int unsigned PD1 = 2, LAT1 = 2, POL1 = 0;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_scan_if bus0 ();
  vga_scan_if bus1 ();

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL0), .PIX_DIV(PD0), .RD_LATENCY(LAT0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL1), .PIX_DIV(PD1), .RD_LATENCY(LAT1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Frame-buffer model: returns {y[3:0], x[7:0]} after the read latency.
  logic [11:0] buf0_q;
  logic [11:0] buf1_q [2];
  always @(posedge clk) begin
    buf0_q    <= {bus0.y[3:0], bus0.x[7:0]};
    buf1_q[0] <= {bus1.y[3:0], bus1.x[7:0]};
    buf1_q[1] <= buf1_q[0];
  end
  assign bus0.colour_in = buf0_q;
  assign bus1.colour_in = buf1_q[1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q0[$];
  exp_t q1[$];
  int unsigned m_div [2];
  int unsigned m_h [2];
  int unsigned m_v [2];
  logic        m_trig [2];
  int   last_trig [2];
  int   since_rel [2];
  int   trig_run [2];
  int   hs_run [2];
  int   vs_run [2];
  int   hs_cnt [2];
  logic trig_pending [2];
  int unsigned x_max = 0;
  int unsigned y_max = 0;

  function automatic int unsigned pd_of(input int d);
    return (d == 0) ? PD0 : PD1;
  endfunction

  function automatic logic pol_of(input int d);
    return (d == 0) ? (POL0 != 0) : (POL1 != 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input int d, input int unsigned h, input int unsigned v);
    exp_t e;
    logic hs_in, vs_in;
    e.h   = 11'(h);
    e.v   = 10'(v);
    e.de  = (h < HA) && (v < VA);
    hs_in = (h >= HA + HF) && (h < HA + HF + HS);
    vs_in = (v >= VA + VF) && (v < VA + VF + VS);
    e.hs  = pol_of(d) ? hs_in : !hs_in;
    e.vs  = pol_of(d) ? vs_in : !vs_in;
    e.rgb = e.de ? {v[3:0], h[7:0]} : 12'h000;
    return e;
  endfunction

  task automatic sb_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_div[d] = 0; m_h[d] = 0; m_v[d] = 0; m_trig[d] = 1'b0;
      last_trig[d] = -1; since_rel[d] = 0;
      trig_run[d] = 0; hs_run[d] = 0; vs_run[d] = 0; hs_cnt[d] = 0;
      trig_pending[d] = 1'b1;
    end
    repeat (LAT0) q0.push_back(mk_exp(0, HA, VA));
    repeat (LAT1) q1.push_back(mk_exp(1, HA, VA));
  endtask

  task automatic model_adv(input int d);
    logic tick;
    tick = (m_div[d] == pd_of(d) - 1);
    m_trig[d] = tick && (m_h[d] == HT - 1) && (m_v[d] == VA - 1);
    if (tick) begin
      m_div[d] = 0;
      if (m_h[d] == HT - 1) begin
        m_h[d] = 0;
        m_v[d] = (m_v[d] == VT - 1) ? 0 : m_v[d] + 1;
      end else begin
        m_h[d] = m_h[d] + 1;
      end
    end else begin
      m_div[d] = m_div[d] + 1;
    end
  endtask

  task automatic compare(input int d, input logic [10:0] x, input logic [9:0] y,
                         input logic trig, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic hs, input logic vs,
                         input logic act);
    exp_t e;
    logic pol;
    int unsigned pw, ex, ey;
    e   = (d == 0) ? q0.pop_front() : q1.pop_front();
    pol = pol_of(d);
    pw  = pd_of(d);
    ex  = (m_h[d] < HA) ? m_h[d] : 0;
    ey  = (m_v[d] < VA) ? m_v[d] : 0;
    check($sformatf("d%0d rgb", d),    32'({r, g, b}), 32'(e.rgb));
    check($sformatf("d%0d hsync", d),  32'(hs),  32'(e.hs));
    check($sformatf("d%0d vsync", d),  32'(vs),  32'(e.vs));
    check($sformatf("d%0d active", d), 32'(act), 32'(e.de));
    check($sformatf("d%0d x", d),      32'(x),   ex);
    check($sformatf("d%0d y", d),      32'(y),   ey);
    check($sformatf("d%0d frame_trig", d), 32'(trig), 32'(m_trig[d]));
    if (d == 0 && e.de && e.h == 11'd0 && e.v == 10'd5)
      check("line5 first pixel", 32'({r, g, b}), 32'h500);
    if (d == 0 && e.de && e.h == 11'(HA - 1))
      check("last pixel gb", 32'({g, b}), 32'hFF);
    if (d == 0 && e.h == 11'(HA) && e.v < 10'(VA))
      check("first blank pixel", 32'({r, g, b}), 32'h000);
    // Frame-level timing: periods and pulse widths measured in clks.
    if (trig) begin
      trig_run[d]++;
      if (trig_run[d] == 1) begin
        if (trig_pending[d])
          check($sformatf("d%0d release->trig", d), 32'(since_rel[d]), 32'(VA * HT * pw));
        trig_pending[d] = 1'b0;
        if (last_trig[d] >= 0) begin
          check($sformatf("d%0d frame period", d), 32'(cyc - last_trig[d]), 32'(HT * VT * pw));
          check($sformatf("d%0d hsync pulses", d), 32'(hs_cnt[d]), 32'(VT));
        end
        last_trig[d] = cyc;
        hs_cnt[d] = 0;
      end
    end else if (trig_run[d] > 0) begin
      check($sformatf("d%0d trig width", d), 32'(trig_run[d]), 32'd1);
      trig_run[d] = 0;
    end
    if (hs == pol) begin
      hs_run[d]++;
      if (hs_run[d] == 1) hs_cnt[d]++;
    end else if (hs_run[d] > 0) begin
      check($sformatf("d%0d hsync width", d), 32'(hs_run[d]), 32'(HS * pw));
      hs_run[d] = 0;
    end
    if (vs == pol) begin
      vs_run[d]++;
    end else if (vs_run[d] > 0) begin
      check($sformatf("d%0d vsync width", d), 32'(vs_run[d]), 32'(VS * HT * pw));
      vs_run[d] = 0;
    end
    if (d == 0) begin
      if (32'(x) > x_max) x_max = 32'(x);
      if (32'(y) > y_max) y_max = 32'(y);
    end
  endtask

  task automatic chk_rst(input int d, input logic [10:0] x, input logic [9:0] y,
                         input logic trig, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic hs, input logic vs,
                         input logic act);
    check($sformatf("d%0d rst x", d),     32'(x),    32'd0);
    check($sformatf("d%0d rst y", d),     32'(y),    32'd0);
    check($sformatf("d%0d rst trig", d),  32'(trig), 32'd0);
    check($sformatf("d%0d rst rgb", d),   32'({r, g, b}), 32'd0);
    check($sformatf("d%0d rst active", d), 32'(act), 32'd0);
    check($sformatf("d%0d rst hsync", d), 32'(hs),   32'(!pol_of(d)));
    check($sformatf("d%0d rst vsync", d), 32'(vs),   32'(!pol_of(d)));
  endtask

  task automatic chk_rst_all();
    chk_rst(0, bus0.x, bus0.y, bus0.frame_trig, bus0.vga_r, bus0.vga_g, bus0.vga_b,
            bus0.hsync, bus0.vsync, bus0.active);
    chk_rst(1, bus1.x, bus1.y, bus1.frame_trig, bus1.vga_r, bus1.vga_g, bus1.vga_b,
            bus1.hsync, bus1.vsync, bus1.active);
  endtask

  task automatic step();
    q0.push_back(mk_exp(0, m_h[0], m_v[0]));
    q1.push_back(mk_exp(1, m_h[1], m_v[1]));
    @(posedge clk);
    cyc++;
    since_rel[0]++;
    since_rel[1]++;
    model_adv(0);
    model_adv(1);
    #1;
    compare(0, bus0.x, bus0.y, bus0.frame_trig, bus0.vga_r, bus0.vga_g, bus0.vga_b,
            bus0.hsync, bus0.vsync, bus0.active);
    compare(1, bus1.x, bus1.y, bus1.frame_trig, bus1.vga_r, bus1.vga_g, bus1.vga_b,
            bus1.hsync, bus1.vsync, bus1.active);
  endtask

  initial begin
    logic found;
    sb_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_rst_all();

    @(negedge clk);
    rst = 1'b1;
    sb_reset();
    repeat (2 * HT * VT * PD1 + 64) step();

    // Walk dut0 to mid-line, mid-frame, then reset asynchronously.
    found = 1'b0;
    for (int i = 0; i < int'(HT * VT) && !found; i++) begin
      if (m_h[0] == HA / 2 && m_v[0] == VA / 2) found = 1'b1;
      else step();
    end
    check("seek mid-frame", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_rst_all();
    repeat (3) @(posedge clk);
    #1;
    chk_rst_all();

    @(negedge clk);
    rst = 1'b1;
    sb_reset();
    repeat (HT * VT * PD1 + 64) step();

    check("d0 trig after release", 32'(trig_pending[0]), 32'd0);
    check("d1 trig after release", 32'(trig_pending[1]), 32'd0);
    check("x max", x_max, 32'(HA - 1));
    check("y max", y_max, 32'(VA - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
